// File: rtl/toy_eu_forward_stage.sv
// -----------------------------------------------------------------------------
// toy_eu_forward_stage
//
// Single-entry operand-resolve stage sitting between issue and an execution
// unit. One issued instruction is held; each source operand is taken either
// from the register-file value supplied at issue or from an EU write-back
// channel a scheduled number of cycles later. Once every operand is resolved
// the instruction is offered downstream with a valid/ready handshake.
//
// Optional feature (macro TOY_FWD_SAME_CYCLE_BYPASS_EN):
//   When defined, the entry is also offered in WAIT during the cycle in which
//   every remaining pending operand captures, with the write-back data muxed
//   straight onto out_src_val. When undefined, outputs come from the entry
//   registers only.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_vld / in_rdy   issue handshake
//   in_pld            sideband payload, passed through unmodified
//   in_src_val        register-file operand values (operand i at [i*REG_WIDTH])
//   in_src_fwd_en     operand i comes from a forward instead of in_src_val
//   in_src_fwd_id     producing EU index per operand
//   in_src_fwd_dly    forward delay per operand, 0..FWD_DEPTH (saturated)
//   wb_vld, wb_data   per-EU write-back bus
//   cancel_en         flush; highest priority
//   out_vld / out_rdy downstream handshake
//   out_pld           held payload
//   out_src_val       resolved operand values
//   fwd_miss          an operand was due this cycle but its EU had no write-back
// -----------------------------------------------------------------------------
module toy_eu_forward_stage #(
  parameter int EU_NUM    = 8,
  parameter int REG_WIDTH = 64,
  parameter int SRC_NUM   = 3,
  parameter int FWD_DEPTH = 3,
  parameter int PLD_WIDTH = 160,
  localparam int IW = $clog2(EU_NUM),
  localparam int CW = $clog2(FWD_DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_vld,
  output logic                         in_rdy,
  input  logic [PLD_WIDTH-1:0]         in_pld,
  input  logic [SRC_NUM*REG_WIDTH-1:0] in_src_val,
  input  logic [SRC_NUM-1:0]           in_src_fwd_en,
  input  logic [SRC_NUM*IW-1:0]        in_src_fwd_id,
  input  logic [SRC_NUM*CW-1:0]        in_src_fwd_dly,
  input  logic [EU_NUM-1:0]            wb_vld,
  input  logic [EU_NUM*REG_WIDTH-1:0]  wb_data,
  input  logic                         cancel_en,
  output logic                         out_vld,
  input  logic                         out_rdy,
  output logic [PLD_WIDTH-1:0]         out_pld,
  output logic [SRC_NUM*REG_WIDTH-1:0] out_src_val,
  output logic                         fwd_miss
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

  typedef logic [SRC_NUM-1:0][REG_WIDTH-1:0] opv_t;
  typedef logic [EU_NUM-1:0][REG_WIDTH-1:0]  wbv_t;

  // Delays beyond the forward window are clamped to the deepest slot.
  function automatic logic [CW-1:0] sat_dly(input logic [CW-1:0] d);
    if (int'(d) > FWD_DEPTH) sat_dly = CW'(FWD_DEPTH);
    else                     sat_dly = d;
  endfunction

  // EU lookups walk the channel list so an id outside EU_NUM reads as
  // "no write-back" instead of indexing past the bus.
  function automatic logic eu_hit(input logic [IW-1:0]     id,
                                  input logic [EU_NUM-1:0] vld);
    eu_hit = 1'b0;
    for (int e = 0; e < EU_NUM; e++)
      if (id == IW'(e)) eu_hit = vld[e];
  endfunction

  function automatic logic [REG_WIDTH-1:0] eu_data(input logic [IW-1:0] id,
                                                   input wbv_t          data);
    eu_data = '0;
    for (int e = 0; e < EU_NUM; e++)
      if (id == IW'(e)) eu_data = data[e];
  endfunction

  state_t                     state_q, state_d;
  logic [PLD_WIDTH-1:0]       pld_q, pld_d;
  opv_t                       val_q, val_d;
  logic [SRC_NUM-1:0]         pend_q, pend_d, pend_new;
  logic [SRC_NUM-1:0][IW-1:0] id_q, id_d;
  logic [SRC_NUM-1:0][CW-1:0] cnt_q, cnt_d;

  opv_t                       in_val_a;
  logic [SRC_NUM-1:0][IW-1:0] in_id_a;
  logic [SRC_NUM-1:0][CW-1:0] in_dly_a;
  wbv_t                       wb_data_a;
  opv_t                       out_val_a;

  logic [SRC_NUM-1:0]         hit_now, due_now, acc_hit, acc_d0;
  opv_t                       wb_now, acc_wb;

  logic accept, xfer, miss_run, miss_acc;

  assign in_val_a  = in_src_val;
  assign in_id_a   = in_src_fwd_id;
  assign in_dly_a  = in_src_fwd_dly;
  assign wb_data_a = wb_data;

  // Per-operand write-back lookups, for the resident entry and the incoming one.
  always_comb begin
    hit_now = '0;
    due_now = '0;
    acc_hit = '0;
    acc_d0  = '0;
    wb_now  = '0;
    acc_wb  = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      hit_now[i] = eu_hit(id_q[i], wb_vld);
      wb_now[i]  = eu_data(id_q[i], wb_data_a);
      due_now[i] = pend_q[i] & (cnt_q[i] == '0);
      acc_hit[i] = eu_hit(in_id_a[i], wb_vld);
      acc_wb[i]  = eu_data(in_id_a[i], wb_data_a);
      acc_d0[i]  = in_src_fwd_en[i] & (in_dly_a[i] == '0);
    end
  end

`ifdef TOY_FWD_SAME_CYCLE_BYPASS_EN
  logic all_cap;

  // WAIT can release early when every still-pending operand lands this cycle.
  always_comb begin
    all_cap   = (state_q == ST_WAIT);
    out_val_a = val_q;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (pend_q[i] && !(due_now[i] && hit_now[i])) all_cap = 1'b0;
      if (due_now[i] && hit_now[i]) out_val_a[i] = wb_now[i];
    end
  end

  assign out_vld = ((state_q == ST_READY) | all_cap) & ~cancel_en;
`else
  assign out_val_a = val_q;
  assign out_vld   = (state_q == ST_READY) & ~cancel_en;
`endif

  assign xfer        = out_vld & out_rdy;
  assign in_rdy      = ~cancel_en & ((state_q == ST_EMPTY) | xfer);
  assign accept      = in_vld & in_rdy;
  assign out_pld     = pld_q;
  assign out_src_val = out_val_a;
  assign fwd_miss    = miss_run | miss_acc;

  // Entry update: resident capture first, then flush / new load / release.
  always_comb begin
    state_d  = state_q;
    pld_d    = pld_q;
    val_d    = val_q;
    pend_d   = pend_q;
    id_d     = id_q;
    cnt_d    = cnt_q;
    pend_new = '0;
    miss_run = 1'b0;
    miss_acc = 1'b0;

    // Capture keeps running under backpressure so no write-back is lost.
    for (int i = 0; i < SRC_NUM; i++) begin
      if (pend_q[i]) begin
        if (!due_now[i]) begin
          cnt_d[i] = cnt_q[i] - CW'(1);
        end else if (hit_now[i]) begin
          val_d[i]  = wb_now[i];
          pend_d[i] = 1'b0;
        end else begin
          miss_run = 1'b1;
        end
      end
    end

    // A zero-delay forward resolves at issue only if its EU writes back now.
    for (int i = 0; i < SRC_NUM; i++) begin
      if (acc_d0[i]) pend_new[i] = ~acc_hit[i];
      else           pend_new[i] = in_src_fwd_en[i];
    end

    if (cancel_en) begin
      state_d = ST_EMPTY;
      pend_d  = '0;
    end else if (accept) begin
      pld_d  = in_pld;
      pend_d = pend_new;
      id_d   = in_id_a;
      for (int i = 0; i < SRC_NUM; i++) begin
        val_d[i] = (acc_d0[i] && acc_hit[i]) ? acc_wb[i] : in_val_a[i];
        // Counter holds cycles still to wait before the due cycle.
        cnt_d[i] = (in_src_fwd_en[i] && in_dly_a[i] != '0)
                   ? sat_dly(in_dly_a[i]) - CW'(1) : '0;
        if (acc_d0[i] && !acc_hit[i]) miss_acc = 1'b1;
      end
      state_d = (pend_new != '0) ? ST_WAIT : ST_READY;
    end else if (xfer) begin
      state_d = ST_EMPTY;
    end else if (state_q == ST_WAIT && pend_d == '0) begin
      state_d = ST_READY;
    end
  end

  // Entry register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      pld_q   <= '0;
      val_q   <= '0;
      pend_q  <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pld_q   <= pld_d;
      val_q   <= val_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_toy_eu_forward_stage.sv
// -----------------------------------------------------------------------------
// tb_toy_eu_forward_stage
//
// Directed bench for toy_eu_forward_stage at default parameters. A table of
// single-instruction scenarios (operand sources, one write-back event,
// expected operands and latency) is applied in a loop; hand-written
// sequences cover forward misses, backpressure with back-to-back issue,
// flush, and asynchronous reset while waiting.
// -----------------------------------------------------------------------------
module tb_toy_eu_forward_stage;

  localparam int EU_NUM    = 8;
  localparam int REG_WIDTH = 64;
  localparam int SRC_NUM   = 3;
  localparam int FWD_DEPTH = 3;
  localparam int PLD_WIDTH = 160;
  localparam int IW        = 3;
  localparam int CW        = 2;

`ifdef TOY_FWD_SAME_CYCLE_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic                         in_vld;
  logic                         in_rdy;
  logic [PLD_WIDTH-1:0]         in_pld;
  logic [SRC_NUM*REG_WIDTH-1:0] in_src_val;
  logic [SRC_NUM-1:0]           in_src_fwd_en;
  logic [SRC_NUM*IW-1:0]        in_src_fwd_id;
  logic [SRC_NUM*CW-1:0]        in_src_fwd_dly;
  logic [EU_NUM-1:0]            wb_vld;
  logic [EU_NUM*REG_WIDTH-1:0]  wb_data;
  logic                         cancel_en;
  logic                         out_vld;
  logic                         out_rdy;
  logic [PLD_WIDTH-1:0]         out_pld;
  logic [SRC_NUM*REG_WIDTH-1:0] out_src_val;
  logic                         fwd_miss;

  toy_eu_forward_stage #(
    .EU_NUM(EU_NUM), .REG_WIDTH(REG_WIDTH), .SRC_NUM(SRC_NUM),
    .FWD_DEPTH(FWD_DEPTH), .PLD_WIDTH(PLD_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_pld(in_pld),
    .in_src_val(in_src_val), .in_src_fwd_en(in_src_fwd_en),
    .in_src_fwd_id(in_src_fwd_id), .in_src_fwd_dly(in_src_fwd_dly),
    .wb_vld(wb_vld), .wb_data(wb_data), .cancel_en(cancel_en),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_pld(out_pld),
    .out_src_val(out_src_val), .fwd_miss(fwd_miss)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0][63:0] v;
    logic [2:0]       en;
    logic [2:0][2:0]  id;
    logic [2:0][1:0]  d;
    logic [2:0]       wb_eu;
    logic [3:0]       wb_cyc;   // cycle after accept carrying the write-back; 15 = none
    logic [63:0]      wb_val;
    logic [2:0][63:0] ex;
    logic [3:0]       lat;
    logic [3:0]       lat_byp;
  } vec_t;

  vec_t tbl [6];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [191:0] ops(input logic [63:0] a, input logic [63:0] b,
                                       input logic [63:0] c);
    ops = {c, b, a};
  endfunction

  function automatic vec_t mk(input logic [191:0] v, input logic [2:0] en,
                              input logic [8:0] id, input logic [5:0] d,
                              input logic [2:0] eu, input logic [3:0] cyc,
                              input logic [63:0] wv, input logic [191:0] ex,
                              input logic [3:0] lat, input logic [3:0] latb);
    vec_t m;
    m.v = v; m.en = en; m.id = id; m.d = d; m.wb_eu = eu; m.wb_cyc = cyc;
    m.wb_val = wv; m.ex = ex; m.lat = lat; m.lat_byp = latb;
    return m;
  endfunction

  task automatic idle();
    in_vld         = 1'b0;
    in_pld         = '0;
    in_src_val     = '0;
    in_src_fwd_en  = '0;
    in_src_fwd_id  = '0;
    in_src_fwd_dly = '0;
    wb_vld         = '0;
    wb_data        = '0;
    cancel_en      = 1'b0;
    out_rdy        = 1'b1;
  endtask

  task automatic set_src(input int i, input logic [63:0] v, input logic en,
                         input logic [2:0] id, input logic [1:0] d);
    in_src_val[i*64 +: 64]   = v;
    in_src_fwd_en[i]         = en;
    in_src_fwd_id[i*3 +: 3]  = id;
    in_src_fwd_dly[i*2 +: 2] = d;
  endtask

  task automatic run_vec(input vec_t t, input int n);
    int lat;
    int exp_lat;
    bit seen;
    logic [159:0] pld;
    exp_lat = (BYP != 0) ? int'(t.lat_byp) : int'(t.lat);
    pld     = 160'(32'hA000 + 32'(n));
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    in_pld = pld;
    for (int i = 0; i < 3; i++) set_src(i, t.v[i], t.en[i], t.id[i], t.d[i]);
    wb_data[int'(t.wb_eu)*64 +: 64] = t.wb_val;
    if (t.wb_cyc == 4'd0) wb_vld[t.wb_eu] = 1'b1;
    #1;
    chk($sformatf("v%0d_in_rdy", n), 256'(in_rdy), 256'(1));
    seen = 1'b0;
    lat  = 0;
    for (int k = 1; k <= 8 && !seen; k++) begin
      @(negedge clk);
      in_vld = 1'b0;
      wb_vld = '0;
      if (int'(t.wb_cyc) == k) wb_vld[t.wb_eu] = 1'b1;
      #1;
      if (out_vld) begin
        seen = 1'b1;
        lat  = k;
        chk($sformatf("v%0d_latency", n), 256'(lat), 256'(exp_lat));
        chk($sformatf("v%0d_src", n), 256'(out_src_val), 256'(t.ex));
        chk($sformatf("v%0d_pld", n), 256'(out_pld), 256'(pld));
      end
    end
    if (!seen) chk($sformatf("v%0d_timeout", n), 256'(0), 256'(1));
    @(negedge clk);
    idle();
    #1;
    chk($sformatf("v%0d_empty_after", n), 256'(out_vld), 256'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] hold;
    logic [191:0] prev;
    int           k_out;

    // all register-file operands
    tbl[0] = mk(ops(64'h11, 64'h22, 64'h33), 3'b000, 9'h0, 6'h0, 3'd0, 4'd15, 64'h0,
                ops(64'h11, 64'h22, 64'h33), 4'd1, 4'd1);
    // src1 from EU5, d=2
    tbl[1] = mk(ops(64'h1, 64'h2, 64'h3), 3'b010, {3'd0, 3'd5, 3'd0}, {2'd0, 2'd2, 2'd0},
                3'd5, 4'd2, 64'hBEEF, ops(64'h1, 64'hBEEF, 64'h3), 4'd3, 4'd2);
    // all three from EU7, d=3
    tbl[2] = mk(ops(64'hA, 64'hB, 64'hC), 3'b111, {3'd7, 3'd7, 3'd7}, {2'd3, 2'd3, 2'd3},
                3'd7, 4'd3, 64'h5A5A, ops(64'h5A5A, 64'h5A5A, 64'h5A5A), 4'd4, 4'd3);
    // d=0 forward hitting in the issue cycle
    tbl[3] = mk(ops(64'h9, 64'h8, 64'h7), 3'b001, {3'd0, 3'd0, 3'd2}, 6'h0,
                3'd2, 4'd0, 64'h1234, ops(64'h1234, 64'h8, 64'h7), 4'd1, 4'd1);
    // d=1 on EU0, src2
    tbl[4] = mk(ops(64'h4, 64'h5, 64'h6), 3'b100, 9'h0, {2'd1, 2'd0, 2'd0},
                3'd0, 4'd1, 64'h77, ops(64'h4, 64'h5, 64'h77), 4'd2, 4'd1);
    // two operands on the same EU and cycle, one from the register file
    tbl[5] = mk(ops(64'h55, 64'hE1, 64'hE2), 3'b110, {3'd1, 3'd1, 3'd0}, {2'd1, 2'd1, 2'd0},
                3'd1, 4'd1, 64'hDEAD, ops(64'h55, 64'hDEAD, 64'hDEAD), 4'd2, 4'd1);

    // reset state
    idle();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_out_vld", 256'(out_vld), 256'(0));
    chk("rst_fwd_miss", 256'(fwd_miss), 256'(0));
    chk("rst_in_rdy", 256'(in_rdy), 256'(1));
    chk("rst_out_src", 256'(out_src_val), 256'(0));
    chk("rst_out_pld", 256'(out_pld), 256'(0));

    for (int n = 0; n < 6; n++) run_vec(tbl[n], n);

    // d=1 on EU3 with write-back missing for two cycles
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    set_src(0, 64'h1, 1'b1, 3'd3, 2'd1);
    set_src(1, 64'h2, 1'b0, 3'd0, 2'd0);
    set_src(2, 64'h3, 1'b0, 3'd0, 2'd0);
    wb_data[3*64 +: 64] = 64'hCAFE;
    #1;
    chk("miss_accept_fwd_miss", 256'(fwd_miss), 256'(0));
    k_out = (BYP != 0) ? 3 : 4;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      in_vld    = 1'b0;
      wb_vld    = '0;
      wb_vld[3] = (k == 3);
      #1;
      chk($sformatf("miss_fwd_miss_c%0d", k), 256'(fwd_miss), 256'((k == 1) || (k == 2)));
      chk($sformatf("miss_out_vld_c%0d", k), 256'(out_vld), 256'(k == k_out));
      if (k == k_out)
        chk("miss_src", 256'(out_src_val), 256'(ops(64'hCAFE, 64'h2, 64'h3)));
    end

    // d=0 forward that misses in the issue cycle
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    set_src(0, 64'h1, 1'b1, 3'd4, 2'd0);
    wb_data[4*64 +: 64] = 64'h44;
    #1;
    chk("d0miss_fwd_miss", 256'(fwd_miss), 256'(1));
    k_out = (BYP != 0) ? 1 : 2;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      in_vld    = 1'b0;
      wb_vld    = '0;
      wb_vld[4] = (k == 1);
      #1;
      chk($sformatf("d0miss_out_vld_c%0d", k), 256'(out_vld), 256'(k == k_out));
      if (k == k_out)
        chk("d0miss_src", 256'(out_src_val), 256'(ops(64'h44, 64'h0, 64'h0)));
    end

    // backpressure: READY held for 5 cycles while everything else churns
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    in_pld = 160'hBB;
    hold   = ops(64'hA1, 64'hA2, 64'hA3);
    in_src_val = hold;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      out_rdy    = 1'b0;
      in_vld     = 1'b1;
      in_pld     = 160'hDD;
      in_src_val = ops(64'hF0, 64'hF1, 64'hF2);
      wb_vld     = '1;
      for (int e = 0; e < EU_NUM; e++) wb_data[e*64 +: 64] = {$urandom, $urandom};
      #1;
      chk($sformatf("bp_out_vld_c%0d", k), 256'(out_vld), 256'(1));
      chk($sformatf("bp_in_rdy_c%0d", k), 256'(in_rdy), 256'(0));
      chk($sformatf("bp_src_c%0d", k), 256'(out_src_val), 256'(hold));
      chk($sformatf("bp_pld_c%0d", k), 256'(out_pld), 256'(160'hBB));
    end

    // back-to-back issue with out_rdy=1: one accept and one transfer per cycle
    prev = hold;
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      idle();
      in_vld     = 1'b1;
      in_pld     = 160'(32'hC00 + 32'(j));
      in_src_val = ops(64'(32'h100 * (j + 1) + 1), 64'(32'h100 * (j + 1) + 2),
                       64'(32'h100 * (j + 1) + 3));
      #1;
      chk($sformatf("b2b_in_rdy_%0d", j), 256'(in_rdy), 256'(1));
      chk($sformatf("b2b_out_vld_%0d", j), 256'(out_vld), 256'(1));
      chk($sformatf("b2b_src_%0d", j), 256'(out_src_val), 256'(prev));
      prev = in_src_val;
    end
    @(negedge clk);
    idle();
    #1;
    chk("b2b_last_vld", 256'(out_vld), 256'(1));
    chk("b2b_last_src", 256'(out_src_val), 256'(prev));
    chk("b2b_last_pld", 256'(out_pld), 256'(160'hC03));
    @(negedge clk);
    #1;
    chk("b2b_drained", 256'(out_vld), 256'(0));

    // flush while WAIT, with a colliding issue in the flush cycle
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    set_src(0, 64'h1, 1'b1, 3'd6, 2'd3);
    @(negedge clk);
    cancel_en  = 1'b1;
    in_vld     = 1'b1;
    in_src_fwd_en = '0;
    in_src_val = ops(64'h99, 64'h99, 64'h99);
    #1;
    chk("cancel_out_vld", 256'(out_vld), 256'(0));
    chk("cancel_in_rdy", 256'(in_rdy), 256'(0));
    @(negedge clk);
    idle();
    #1;
    chk("cancel_empty_in_rdy", 256'(in_rdy), 256'(1));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wb_vld[6] = 1'b1;
      wb_data[6*64 +: 64] = 64'h6666;
      #1;
      chk($sformatf("cancel_no_out_c%0d", k), 256'(out_vld), 256'(0));
    end

    // flush while READY blocks the transfer
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    in_src_val = ops(64'h12, 64'h34, 64'h56);
    @(negedge clk);
    idle();
    cancel_en = 1'b1;
    #1;
    chk("cancel_ready_out_vld", 256'(out_vld), 256'(0));
    @(negedge clk);
    idle();
    #1;
    chk("cancel_ready_empty", 256'(out_vld), 256'(0));

    // asynchronous reset while WAIT
    @(negedge clk);
    idle();
    in_vld = 1'b1;
    in_pld = 160'hEE;
    set_src(0, 64'h31, 1'b1, 3'd2, 2'd3);
    set_src(1, 64'h32, 1'b0, 3'd0, 2'd0);
    @(negedge clk);
    idle();
    rst_n = 1'b0;
    #1;
    chk("arst_out_vld", 256'(out_vld), 256'(0));
    chk("arst_in_rdy", 256'(in_rdy), 256'(1));
    chk("arst_pld", 256'(out_pld), 256'(0));
    chk("arst_src", 256'(out_src_val), 256'(0));
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      wb_vld[2] = 1'b1;
      wb_data[2*64 +: 64] = 64'h2222;
      #1;
      chk($sformatf("arst_no_out_c%0d", k), 256'(out_vld), 256'(0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/toy_eu_forward_stage.md
Name: toy_eu_forward_stage

Overview:
- Single-entry operand-resolve stage between issue and an execution unit (EU).
- Holds one issued instruction and captures each pending source operand from the EU write-back bus on its scheduled cycle.
- Releases the instruction once every operand is resolved, using a valid/ready handshake.
- Parametrised in source count, EU count, forward depth and payload width; supports multi-cycle forward delay, downstream backpressure and flush.

Parameters:
- EU_NUM, 8, number of write-back channels.
- REG_WIDTH, 64, operand width in bits.
- SRC_NUM, 3, source operands per instruction.
- FWD_DEPTH, 3, maximum forward delay in cycles.
- PLD_WIDTH, 160, opaque sideband payload width.
- Derived: IW=$clog2(EU_NUM), CW=$clog2(FWD_DEPTH+1).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- in_vld  in  1  issue valid
- in_rdy  out  1  issue ready
- in_pld  in  PLD_WIDTH  sideband payload, passed through unmodified
- in_src_val  in  SRC_NUM*REG_WIDTH  register-file operand values
- in_src_fwd_en  in  SRC_NUM  operand i is taken from forward, not register file
- in_src_fwd_id  in  SRC_NUM*IW  producing EU index per operand
- in_src_fwd_dly  in  SRC_NUM*CW  forward delay d per operand, 0..FWD_DEPTH
- wb_vld  in  EU_NUM  write-back valid per EU
- wb_data  in  EU_NUM*REG_WIDTH  write-back data per EU
- cancel_en  in  1  flush
- out_vld  out  1  instruction resolved
- out_rdy  in  1  consumer ready
- out_pld  out  PLD_WIDTH  held payload
- out_src_val  out  SRC_NUM*REG_WIDTH  resolved operand values
- fwd_miss  out  1  pulse: an operand was due this cycle but its EU's wb_vld was low

Behaviour:
- Entry states:
  - EMPTY: no instruction held.
  - WAIT: instruction held, at least one operand pending.
  - READY: all operands resolved.
- Reset values: state EMPTY; all payload, operand, counter and pending registers 0; out_vld=0; fwd_miss=0; in_rdy=1.
- Handshake signals:
  - in_rdy = ~cancel_en & (state==EMPTY | out_vld&out_rdy).
  - accept = in_vld & in_rdy.
  - out_vld = (state==READY) & ~cancel_en.
  - Transfer = out_vld & out_rdy.
- On accept (cycle A), for each operand i:
  - fwd_en=0: latch in_src_val; operand resolved.
  - fwd_en=1 and d=0: if wb_vld[id], latch wb_data[id] and resolve. Otherwise set pending with cnt=0 and pulse fwd_miss.
  - fwd_en=1 and d≥1: latch in_src_val, set pending, cnt=d-1.
  - d>FWD_DEPTH is illegal; the block saturates d to FWD_DEPTH.
- In every cycle after accept, for each pending operand:
  - cnt≠0: decrement cnt.
  - cnt==0 and wb_vld[id]: latch wb_data[id], clear pending.
  - cnt==0 and ~wb_vld[id]: stay pending, assert fwd_miss this cycle; capture on the next cycle where wb_vld[id]=1.
- Capture continues regardless of out_rdy; backpressure never loses write-back data.
- State transitions:
  - EMPTY→WAIT on accept with any operand left pending.
  - EMPTY→READY on accept with all operands resolved.
  - WAIT→READY at the clock edge where the last pending operand clears.
  - READY→EMPTY on transfer without a same-cycle accept.
  - Transfer with a same-cycle accept loads the new entry; there is no bubble.
- Latency:
  - All operands resolved at accept: out_vld in cycle A+1.
  - Otherwise: out_vld one cycle after the cycle in which the last operand is captured. Worst case with no misses is A+FWD_DEPTH+1.
- cancel_en has highest priority:
  - State goes to EMPTY at the next edge; all pending bits clear.
  - Any in_vld in the cancel cycle is dropped.
  - out_vld is forced low in the cancel cycle, so no transfer occurs.
- Simultaneous events:
  - Several operands on the same EU and cycle capture the same wb_data.
  - Operands sourcing different EUs capture independently.
- out_pld and out_src_val hold stable while out_vld=1 & out_rdy=0.
- Asserting rst_n low mid-WAIT returns the block immediately to reset values.

Optional Feature:
- Macro: TOY_FWD_SAME_CYCLE_BYPASS_EN.
- Defined:
  - out_vld also asserts in state WAIT when every remaining pending operand captures in the current cycle.
  - out_src_val muxes wb_data combinationally for those operands.
  - Latency drops by 1 (minimum A+d for d≥1).
  - A transfer in that cycle releases the entry; captured values are not re-registered.
- Undefined: all outputs are driven from registers only, as specified above.

Test Plan:
- Reset, then in_vld=1 with fwd_en=0, src0=0x11, src1=0x22, src2=0x33, out_rdy=1 -> out_vld=1 at A+1 carrying 0x11/0x22/0x33; then EMPTY.
- src1 fwd_en=1, id=5, d=2; wb_vld[5]=1 with wb_data=0xBEEF at A+2 -> out_vld at A+3, src1=0xBEEF (A+2 with bypass macro).
- d=1 on EU3 but wb_vld[3]=0 at A+1 and 1 at A+3 with 0xCAFE -> fwd_miss high at A+1 and A+2; out_vld at A+4, src=0xCAFE.
- out_rdy=0 while READY for 5 cycles, wb activity on all EUs -> out_src_val/out_pld unchanged, in_rdy=0; back-to-back issue with out_rdy=1 accepts every cycle.
- cancel_en at A+1 while in WAIT, in_vld=1 same cycle -> out_vld=0 and in_rdy=0 that cycle; state EMPTY at A+2; dropped instruction never appears.
- Three operands all id=7, d=3, wb_data[7]=0x5A5A at A+3 -> all three resolve to 0x5A5A; out_vld at A+4.
